// File: rtl/reg_hazard_scoreboard_if.sv
// Issue/WB/status bundle for reg_hazard_scoreboard.
// The ID/WB side drives through the master modport; the scoreboard uses the slave modport.
interface reg_hazard_scoreboard_if #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int STALL_W  = 16
);
    logic                issue_valid;
    logic                issue_ready;
    logic [ADDR_W-1:0]   rs;
    logic [ADDR_W-1:0]   rt;
    logic [ADDR_W-1:0]   dest;
    logic                uses_rs;
    logic                uses_rt;
    logic                writes_reg;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_reg;
    logic                flush;
    logic [NUM_REGS-1:0] busy_mask;
    logic                stall;
    logic [STALL_W-1:0]  stall_count;
    logic                wb_err;

    modport master (
        output issue_valid, rs, rt, dest, uses_rs, uses_rt, writes_reg,
               wb_valid, wb_reg, flush,
        input  issue_ready, busy_mask, stall, stall_count, wb_err
    );

    modport slave (
        input  issue_valid, rs, rt, dest, uses_rs, uses_rt, writes_reg,
               wb_valid, wb_reg, flush,
        output issue_ready, busy_mask, stall, stall_count, wb_err
    );
endinterface

// File: rtl/reg_hazard_scoreboard.sv
// RAW/WAW hazard scoreboard: one pending-write counter per register, issue gating, stall stats.
// Optional macro SCOREBOARD_WB_BYPASS_EN: a source whose last write retires this cycle is not pending.

module reg_hazard_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_busy
);
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [CNT_W-1:0] w_nxt;

    // inc at MAX and dec at 0 are masked upstream, so no saturation logic is needed here
    always_comb begin
        w_nxt = r_cnt;
        if (i_clr)              w_nxt = '0;
        else if (i_inc && !i_dec) w_nxt = r_cnt + CNT_W'(1);
        else if (i_dec && !i_inc) w_nxt = r_cnt - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_nxt;
            r_busy <= (w_nxt != '0);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_busy = r_busy;
endmodule

module reg_hazard_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int CNT_W    = 2,
    parameter int STALL_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    reg_hazard_scoreboard_if.slave   sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt;
    logic [NUM_REGS-1:0]            w_busy;
    logic [NUM_REGS-1:0]            w_pend;
    logic [NUM_REGS-1:0]            w_inc;
    logic [NUM_REGS-1:0]            w_dec;
    logic                           w_hazard;
    logic                           w_ready;
    logic                           w_fire;
    logic                           w_stall;
    logic [STALL_W-1:0]             r_stall_cnt;
    logic                           r_wb_err;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
`ifdef SCOREBOARD_WB_BYPASS_EN
        // bank is write-before-read, so the retiring value is already visible to the reader
        assign w_pend[g] = (w_cnt[g] != '0) &&
                           !(sb.wb_valid && (sb.wb_reg == ADDR_W'(g)) && (w_cnt[g] == CNT_W'(1)));
`else
        assign w_pend[g] = (w_cnt[g] != '0);
`endif
        assign w_inc[g] = w_fire && sb.writes_reg && (sb.dest == ADDR_W'(g));
        assign w_dec[g] = sb.wb_valid && !sb.flush && (sb.wb_reg == ADDR_W'(g)) && (w_cnt[g] != '0);

        reg_hazard_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .i_inc   (w_inc[g]),
            .i_dec   (w_dec[g]),
            .i_clr   (sb.flush),
            .o_cnt   (w_cnt[g]),
            .o_busy  (w_busy[g])
        );
    end

    // dest at MAX blocks even with a same-cycle WB to it: keeps the counter overflow-free
    assign w_hazard = (sb.uses_rs && w_pend[sb.rs]) ||
                      (sb.uses_rt && w_pend[sb.rt]) ||
                      (sb.writes_reg && (w_cnt[sb.dest] == CNT_MAX));
    assign w_ready  = !w_hazard && !sb.flush;
    assign w_fire   = sb.issue_valid && w_ready;
    assign w_stall  = sb.issue_valid && !w_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_wb_err    <= 1'b0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
            if (sb.wb_valid && !sb.flush && (w_cnt[sb.wb_reg] == '0))
                r_wb_err <= 1'b1;
        end
    end

    assign sb.issue_ready = w_ready;
    assign sb.stall       = w_stall;
    assign sb.busy_mask   = w_busy;
    assign sb.stall_count = r_stall_cnt;
    assign sb.wb_err      = r_wb_err;
endmodule
